// File: rtl/flash_page_buffer.sv
// Flash page buffer: collects upstream bytes into a page-sized buffer, then
// hands the page to a page-program controller (key pulse + addr/pp_num/mode)
// and streams the bytes out one per byte_req.
//
// Ports:
//   system_clk, system_reset   clock, async active-high reset
//   start, base_addr           load next page address (only when buffer empty)
//   mode_in                    PP (0) / PPX4 (1), latched into mode at launch
//   wr_valid, wr_data, wr_ready upstream byte handshake (FILL only)
//   flush                      launch a partial, non-empty page
//   byte_req, pp_done          downstream consume / program-complete strobes
//   key, addr, pp_num, mode    launch pulse and page descriptor
//   data                       byte currently presented to the controller
//   busy                       high whenever not in FILL
//   pages_written              completed page count (wraps)
module flash_page_buffer #(
  parameter int unsigned PAGE_BYTES = 256
) (
  input  logic        system_clk,
  input  logic        system_reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        mode_in,
  input  logic        wr_valid,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  input  logic        flush,
  input  logic        byte_req,
  input  logic        pp_done,
  output logic        key,
  output logic [31:0] addr,
  output logic [8:0]  pp_num,
  output logic [7:0]  data,
  output logic        mode,
  output logic        busy,
  output logic [15:0] pages_written
);

  localparam int unsigned PTR_W = $clog2(PAGE_BYTES);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PAGE_BYTES);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_LAUNCH,
    ST_PROGRAM,
    ST_ADVANCE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   last_ptr_c;
  logic [31:0]        pg_addr_q, pg_addr_d;
  logic [31:0]        addr_q, addr_d;
  logic [8:0]         pp_num_q, pp_num_d;
  logic [7:0]         data_q, data_d;
  logic               mode_q, mode_d;
  logic               key_q, key_d;
  logic               busy_q, busy_d;
  logic               wr_ready_q, wr_ready_d;
  logic [15:0]        pages_q, pages_d;
  logic               wr_en_c;

  logic [7:0]         mem [PAGE_BYTES];

  // Index of the last valid byte; rd_ptr saturates here.
  assign last_ptr_c = PTR_W'(cnt_q - CNT_W'(1));

  // Page storage; intentionally not reset.
  always_ff @(posedge system_clk) begin
    if (wr_en_c) begin
      mem[cnt_q[PTR_W-1:0]] <= wr_data;
    end
  end

  // Next-state and output-register logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    pg_addr_d  = pg_addr_q;
    addr_d     = addr_q;
    pp_num_d   = pp_num_q;
    data_d     = data_q;
    mode_d     = mode_q;
    pages_d    = pages_q;
    wr_en_c    = 1'b0;

    unique case (state_q)
      ST_FILL: begin
        wr_en_c = wr_valid && wr_ready_q;
        if (start && (cnt_q == '0)) begin
          pg_addr_d = base_addr;
        end
        if (wr_en_c) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // Flush only counts once at least one byte (possibly this one) is held.
        if ((cnt_d == FULL_CNT) || (flush && (cnt_d != '0))) begin
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_PROGRAM;
      end
      ST_PROGRAM: begin
        if (byte_req) begin
          if (rd_ptr_q < last_ptr_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
          end
          data_d = mem[rd_ptr_d];
        end
        if (pp_done) begin
          state_d = ST_ADVANCE;
        end
      end
      ST_ADVANCE: begin
        pg_addr_d = pg_addr_q + 32'(PAGE_BYTES);
        cnt_d     = '0;
        pages_d   = pages_q + 16'd1;
        state_d   = ST_FILL;
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase

    // Descriptor is loaded on the edge entering LAUNCH so it is valid with key.
    // Byte 0 may be written on this same edge, hence the bypass.
    if ((state_q == ST_FILL) && (state_d == ST_LAUNCH)) begin
      addr_d   = pg_addr_d;
      pp_num_d = 9'(cnt_d - CNT_W'(1));
      mode_d   = mode_in;
      rd_ptr_d = '0;
      data_d   = (wr_en_c && (cnt_q == '0)) ? wr_data : mem[0];
    end

    key_d      = (state_d == ST_LAUNCH);
    busy_d     = (state_d != ST_FILL);
    wr_ready_d = (state_d == ST_FILL) && (cnt_d < FULL_CNT);
  end

  // State and output registers.
  always_ff @(posedge system_clk or posedge system_reset) begin
    if (system_reset) begin
      state_q    <= ST_FILL;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      pg_addr_q  <= '0;
      addr_q     <= '0;
      pp_num_q   <= '0;
      data_q     <= '0;
      mode_q     <= 1'b0;
      key_q      <= 1'b0;
      busy_q     <= 1'b0;
      wr_ready_q <= 1'b0;
      pages_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      pg_addr_q  <= pg_addr_d;
      addr_q     <= addr_d;
      pp_num_q   <= pp_num_d;
      data_q     <= data_d;
      mode_q     <= mode_d;
      key_q      <= key_d;
      busy_q     <= busy_d;
      wr_ready_q <= wr_ready_d;
      pages_q    <= pages_d;
    end
  end

  assign wr_ready      = wr_ready_q;
  assign key           = key_q;
  assign addr          = addr_q;
  assign pp_num        = pp_num_q;
  assign data          = data_q;
  assign mode          = mode_q;
  assign busy          = busy_q;
  assign pages_written = pages_q;

endmodule

// File: doc/flash_page_buffer.md
FLASH_PAGE_BUFFER -- requirements
Module: flash_page_buffer

Interface
REQ-001 SHALL have parameter PAGE_BYTES, default 256, bytes per page program; legal values are powers of two from 2 to 256.
REQ-002 SHALL have port system_clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port system_reset  input  1  asynchronous active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle pulse that loads base_addr as the next page address.
REQ-005 SHALL have port base_addr  input  32  first flash address, sampled on start.
REQ-006 SHALL have port mode_in  input  1  0 = PP, 1 = PPX4, sampled in LAUNCH.
REQ-007 SHALL have port wr_valid  input  1  upstream byte valid.
REQ-008 SHALL have port wr_data  input  8  upstream byte.
REQ-009 SHALL have port wr_ready  output  1  buffer accepts a byte this cycle.
REQ-010 SHALL have port flush  input  1  launch a partial page.
REQ-011 SHALL have port byte_req  input  1  downstream page-program controller has consumed the current data byte.
REQ-012 SHALL have port pp_done  input  1  downstream program complete.
REQ-013 SHALL have port key  output  1  one-cycle launch pulse to the page-program controller.
REQ-014 SHALL have port addr  output  32  page start address.
REQ-015 SHALL have port pp_num  output  9  byte count minus 1.
REQ-016 SHALL have port data  output  8  current byte to program.
REQ-017 SHALL have port mode  output  1  latched mode_in.
REQ-018 SHALL have port busy  output  1  high outside FILL.
REQ-019 SHALL have port pages_written  output  16  count of completed pages; wraps at 16 bits.

Function
REQ-020 SHALL implement states FILL, LAUNCH, PROGRAM and ADVANCE, with an internal PAGE_BYTES x 8 buffer, fill count cnt (0..PAGE_BYTES), read pointer rd_ptr and page address pg_addr.
REQ-021 SHALL, in FILL, write wr_data to buffer[cnt] and increment cnt whenever wr_valid and wr_ready are both high.
REQ-022 SHALL make wr_ready a registered output that is high only in FILL with cnt < PAGE_BYTES, and that drops on the same edge that accepts the final byte.
REQ-023 SHALL go FILL to LAUNCH when cnt reaches PAGE_BYTES, or when flush is high and cnt (including a byte accepted that cycle) is nonzero.
REQ-024 SHALL ignore flush when the buffer is empty.
REQ-025 SHALL honour start only in FILL with cnt = 0 (pg_addr <= base_addr) and ignore it otherwise.
REQ-026 SHALL, in LAUNCH (exactly one cycle), drive key = 1, addr = pg_addr, pp_num = cnt-1, mode = mode_in, data = buffer[0] and rd_ptr = 0, then go to PROGRAM.
REQ-027 SHALL, in PROGRAM, advance rd_ptr on each byte_req, with data = buffer[rd_ptr] valid on the cycle after byte_req.
REQ-028 SHALL saturate rd_ptr at cnt-1, so extra byte_req pulses hold the last byte.
REQ-029 SHALL hold addr, pp_num and mode stable throughout PROGRAM.
REQ-030 SHALL go PROGRAM to ADVANCE on pp_done.
REQ-031 SHALL ignore pp_done and byte_req in every state other than PROGRAM.
REQ-032 SHALL, in ADVANCE (one cycle), set pg_addr += PAGE_BYTES modulo 2^32 regardless of cnt, clear cnt, increment pages_written, then return to FILL.
REQ-033 SHALL drive key = 0 in every state other than LAUNCH.

Reset
REQ-034 SHALL, while system_reset is high, asynchronously force state FILL, cnt = 0, rd_ptr = 0, pg_addr = 0, key = 0, addr = 0, pp_num = 0, data = 0, mode = 0, busy = 0, wr_ready = 0 and pages_written = 0.
REQ-035 SHALL raise wr_ready on the first rising edge after reset release.
REQ-036 SHALL abandon any operation in progress when reset is asserted mid-operation, with no pending key after release.
REQ-037 SHALL NOT clear the buffer contents on reset.

Verification
REQ-038 SHALL be verified by: start with base 0x00001000, stream 256 bytes 0x10+i -> one key pulse with addr 0x00001000, pp_num 255, mode 0; 255 byte_req pulses walk data 0x10..0x0F; pp_done -> busy low and next addr 0x00001100, pages_written 1.
REQ-039 SHALL be verified by: mode_in 1, write 5 bytes then flush -> key with pp_num 4, mode 1; a 6th byte_req still shows byte 4.
REQ-040 SHALL be verified by: flush with an empty buffer -> no key, busy stays 0.
REQ-041 SHALL be verified by: wr_valid held high during PROGRAM -> wr_ready 0 and nothing written; the byte is accepted on the first FILL cycle after ADVANCE.
REQ-042 SHALL be verified by: reset asserted mid-PROGRAM -> all outputs reset immediately; after release, 3 bytes plus flush -> addr 0x00000000, pp_num 2.
REQ-043 SHALL be verified by: base 0xFFFFFF00, one full page plus pp_done -> next launch addr 0x00000000.
